lcv_div_seq: RTL and testbench

Iterative radix-2 restoring divider, WIDTH bits, signed or unsigned per operation, with valid/ready handshakes on both sides. It is the inverse companion of the multiply-accumulate DSP blocks. It gives the CPU execute stage a divide/remainder path that does not consume DSP48 slices. One operation is in flight at a time, with fixed latency independent of operand values.

---
 rtl/lcv_div_seq.sv | 111 +++++++++++
 tb/tb_lcv_div_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lcv_div_seq.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed or
// unsigned per operation, fixed latency of WIDTH+1 cycles from accept to result.
module lcv_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  output logic             outp_ready,
  input  logic             inp_signed,
  input  logic [WIDTH-1:0] inp_dividend,
  input  logic [WIDTH-1:0] inp_divisor,
  output logic             outp_valid,
  input  logic             inp_ready,
  output logic [WIDTH-1:0] outp_quot,
  output logic [WIDTH-1:0] outp_rem
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [WIDTH:0]   prem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] orig_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             negq_q;
  logic             negr_q;
  logic             dz_q;
  logic             ovf_q;

  logic [WIDTH:0]   shift_d;
  logic [WIDTH:0]   diff_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? -v : v;
  endfunction

  // Trial subtraction on the shifted partial remainder; MSB set means it went negative.
  assign shift_d = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign diff_d  = shift_d - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inp_valid) begin
            dvd_q   <= magnitude(inp_dividend, inp_signed);
            dvs_q   <= magnitude(inp_divisor, inp_signed);
            orig_q  <= inp_dividend;
            negq_q  <= inp_signed & (inp_dividend[WIDTH-1] ^ inp_divisor[WIDTH-1]);
            negr_q  <= inp_signed & inp_dividend[WIDTH-1];
            dz_q    <= (inp_divisor == '0);
            ovf_q   <= inp_signed && (inp_dividend == MOST_NEG) && (inp_divisor == '1);
            prem_q  <= '0;
            cnt_q   <= CNT_LOAD;
            state_q <= CALC;
          end
        end
        CALC: begin
          // Dividend register doubles as the quotient shift register.
          prem_q <= diff_d[WIDTH] ? shift_d : diff_d;
          dvd_q  <= {dvd_q[WIDTH-2:0], ~diff_d[WIDTH]};
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          if (dz_q) begin
            quot_q <= '1;
            rem_q  <= orig_q;
          end else if (ovf_q) begin
            quot_q <= orig_q;
            rem_q  <= '0;
          end else begin
            quot_q <= cond_neg(dvd_q, negq_q);
            rem_q  <= cond_neg(prem_q[WIDTH-1:0], negr_q);
          end
          state_q <= DONE;
        end
        DONE: begin
          if (inp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outp_ready = (state_q == IDLE);
  assign outp_valid = (state_q == DONE);
  assign outp_quot  = quot_q;
  assign outp_rem   = rem_q;

endmodule

// File: tb/tb_lcv_div_seq.sv
// Bench for lcv_div_seq: arithmetic reference model with a per-cycle compare
// process, plus directed operations with literal expected results.
module tb_lcv_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         inp_valid;
  logic         outp_ready;
  logic         inp_signed;
  logic [W-1:0] inp_dividend;
  logic [W-1:0] inp_divisor;
  logic         outp_valid;
  logic         inp_ready;
  logic [W-1:0] outp_quot;
  logic [W-1:0] outp_rem;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcv_div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .inp_valid    (inp_valid),
    .outp_ready   (outp_ready),
    .inp_signed   (inp_signed),
    .inp_dividend (inp_dividend),
    .inp_divisor  (inp_divisor),
    .outp_valid   (outp_valid),
    .inp_ready    (inp_ready),
    .outp_quot    (outp_quot),
    .outp_rem     (outp_rem)
  );

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Transaction timing model: cycles remaining until the result, -1 when idle.
  int           m_left  = -1;
  bit           m_known = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit           cmp_en  = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_left  = -1;
      m_q     = '0;
      m_r     = '0;
      m_known = 1'b1;
    end else if (m_left == -1) begin
      if (inp_valid) begin
        {p_q, p_r} = ref_div(inp_signed, inp_dividend, inp_divisor);
        m_left     = W + 1;
        m_known    = 1'b0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_q     = p_q;
        m_r     = p_r;
        m_known = 1'b1;
      end
    end else if (inp_ready) begin
      m_left  = -1;
      m_known = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_ready", 32'(outp_ready), 32'(m_left == -1));
      check("model_valid", 32'(outp_valid), 32'(m_left == 0));
      if (m_known) begin
        check("model_quot", outp_quot, m_q);
        check("model_rem", outp_rem, m_r);
      end
    end
  end

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int hold, input string nm);
    int lat;
    @(negedge clk);
    inp_valid    = 1'b1;
    inp_signed   = s;
    inp_dividend = a;
    inp_divisor  = b;
    inp_ready    = 1'b0;
    @(posedge clk); #1;
    inp_valid    = 1'b0;
    inp_dividend = $urandom;
    inp_divisor  = $urandom;
    inp_signed   = 1'($urandom_range(1));
    lat = 0;
    while (!outp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(W + 1));
    check({nm, "_quot"}, outp_quot, eq);
    check({nm, "_rem"}, outp_rem, er);
    for (int i = 0; i < hold; i++) begin
      inp_valid    = 1'b1;
      inp_dividend = $urandom;
      @(posedge clk); #1;
      check({nm, "_hold_quot"}, outp_quot, eq);
      check({nm, "_hold_rem"}, outp_rem, er);
      check({nm, "_hold_ready"}, 32'(outp_ready), 32'd0);
      check({nm, "_hold_valid"}, 32'(outp_valid), 32'd1);
    end
    inp_valid = 1'b0;
    inp_ready = 1'b1;
    @(posedge clk); #1;
    inp_ready = 1'b0;
    check({nm, "_drain_ready"}, 32'(outp_ready), 32'd1);
    check({nm, "_drain_valid"}, 32'(outp_valid), 32'd0);
  endtask

  int seen_valid;

  initial begin
    rst          = 1'b0;
    inp_valid    = 1'b0;
    inp_signed   = 1'b0;
    inp_dividend = '0;
    inp_divisor  = '0;
    inp_ready    = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk); #1;
    check("reset_ready", 32'(outp_ready), 32'd1);
    check("reset_valid", 32'(outp_valid), 32'd0);
    check("reset_quot", outp_quot, 32'd0);
    check("reset_rem", outp_rem, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          0, "u100_7");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "s_m7_2");
    run_op(1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          0, "s_7_m2");
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 32'd1,          0, "u_big_2");
    run_op(1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF, 32'd5,          0, "s_div0");
    run_op(1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF, 32'd5,          0, "u_div0");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          0, "s_ovf");
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,         32'hFFFF_FFFE, 10, "s_bp");
    run_op(1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          0, "u_back2back");

    // Abort an operation with reset on the 15th edge after accept.
    @(negedge clk);
    inp_valid    = 1'b1;
    inp_signed   = 1'b0;
    inp_dividend = 32'd12345;
    inp_divisor  = 32'd10;
    @(posedge clk); #1;
    inp_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("midreset_valid", 32'(outp_valid), 32'd0);
    check("midreset_ready", 32'(outp_ready), 32'd1);
    check("midreset_quot", outp_quot, 32'd0);
    check("midreset_rem", outp_rem, 32'd0);
    seen_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (outp_valid) seen_valid++;
    end
    check("midreset_no_result", 32'(seen_valid), 32'd0);

    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, "u9_3");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
